// File: rtl/xor_bist_ctrl.sv
// ---------------------------------------------------------------------------
// xor_bist_ctrl
//   Built-in self-test sequencer for a single two-input XOR gate. It applies
//   the four input vectors {a,b} = 00, 01, 10, 11 in order, holds each for
//   SETTLE cycles, samples the gate output c once per vector, and reports the
//   mismatch count and a per-vector failure map.
//
// Parameters
//   SETTLE   : cycles each vector is held before c is sampled (1..15;
//              0 behaves as 1, values above 15 behave as 15)
//
// Configuration macro
//   XOR_BIST_LOOP_EN : when defined, start held high in DONE re-runs the
//                      sequence and results accumulate across runs. When
//                      undefined the block is one-shot and DONE waits for
//                      start to drop.
//
// Ports
//   clk      in   clock, rising-edge active
//   rst      in   synchronous active-high reset
//   start    in   level request to run the sequence (ignored while busy)
//   c        in   output of the XOR gate under test
//   a, b     out  registered operands driven to the gate
//   busy     out  sequence in progress (DRIVE or SAMPLE)
//   done     out  sequence finished (DONE)
//   pass     out  done with no mismatches
//   err_cnt  out  mismatch count, saturating at 15
//   fail_vec out  bit i set when vector i mismatched
// ---------------------------------------------------------------------------
module xor_bist_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [3:0] fail_vec
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned ERR_W      = 4;
    localparam int unsigned VEC_W      = 2;
    localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 :
                                         ((SETTLE > 15) ? 15 : SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(3);
    localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(15);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [3:0]         fail_q, fail_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_d = (vec_q == VEC_LAST) ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
`ifdef XOR_BIST_LOOP_EN
                // Held start restarts immediately; done lasts one cycle
                state_d = start ? S_DRIVE : S_IDLE;
`else
                if (!start) begin
                    state_d = S_IDLE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        vec_d        = vec_q;
        a_d          = a_q;
        b_d          = b_q;
        err_d        = err_q;
        fail_d       = fail_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Fresh run: first vector and cleared results
                    settle_cnt_d = '0;
                    vec_d        = '0;
                    a_d          = 1'b0;
                    b_d          = 1'b0;
                    err_d        = '0;
                    fail_d       = '0;
                end
            end
            S_DRIVE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                // c is only trusted here, after the settle window
                if (c != (a_q ^ b_q)) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    fail_d[vec_q] = 1'b1;
                end
                settle_cnt_d = '0;
                if (vec_q == VEC_LAST) begin
                    vec_d = '0;
                    a_d   = 1'b0;
                    b_d   = 1'b0;
                end else begin
                    vec_d = vec_q + VEC_W'(1);
                    a_d   = vec_d[1];
                    b_d   = vec_d[0];
                end
            end
            S_DONE: begin
`ifdef XOR_BIST_LOOP_EN
                // Looped run keeps accumulating err_cnt and fail_vec
                if (start) begin
                    settle_cnt_d = '0;
                    vec_d        = '0;
                    a_d          = 1'b0;
                    b_d          = 1'b0;
                end
`endif
            end
            default: begin
                settle_cnt_d = '0;
                vec_d        = '0;
                a_d          = 1'b0;
                b_d          = 1'b0;
            end
        endcase

        // Status flags track the state being entered so they line up with it
        busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == '0);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt_q <= '0;
            vec_q        <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_q       <= '0;
        end else begin
            settle_cnt_q <= settle_cnt_d;
            vec_q        <= vec_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_q       <= fail_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_xor_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xor_bist_ctrl
//   Drives two controllers (SETTLE=1 and SETTLE=3) against a modelled gate
//   whose output is a^b with selected vectors inverted by flip_mask. The
//   expected trace is derived from the vector timing and the flip mask.
// ---------------------------------------------------------------------------
module tb_xor_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, start3;
    logic       c1, c3;
    logic       a1, b1, busy1, done1, pass1;
    logic       a3, b3, busy3, done3, pass3;
    logic [3:0] err1, fail1, err3, fail3;
    logic [3:0] flip_mask;

    int n_cmp = 0;
    int n_err = 0;

    // Gate model: correct XOR except on vectors flagged in flip_mask
    assign c1 = (a1 ^ b1) ^ flip_mask[{a1, b1}];
    assign c3 = (a3 ^ b3) ^ flip_mask[{a3, b3}];

    xor_bist_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .c(c1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_vec(fail1)
    );

    xor_bist_ctrl #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .c(c3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .fail_vec(fail3)
    );

    function automatic logic [12:0] observe(input int sel);
        if (sel != 0) return {busy3, done3, pass3, a3, b3, err3, fail3};
        return {busy1, done1, pass1, a1, b1, err1, fail1};
    endfunction

    function automatic logic [12:0] pack_exp(input logic bz, input logic dn,
                                             input logic ps, input logic ea,
                                             input logic eb, input logic [3:0] er,
                                             input logic [3:0] fv);
        return {bz, dn, ps, ea, eb, er, fv};
    endfunction

    task automatic check(input string tag, input logic [12:0] got,
                         input logic [12:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed={busy,done,pass,a,b,err,fail}=%b required=%b",
                   tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start3 = v;
        else          start1 = v;
    endtask

    // One full run from IDLE; optional random start noise while busy
    task automatic run_seq(input int sel, input logic [3:0] mask,
                           input bit noise, input string tag);
        int         s;
        int         len;
        int         idx;
        logic [1:0] v;
        logic [3:0] prior;
        logic [3:0] exp_err;
        s   = (sel != 0) ? 3 : 1;
        len = 4 * (s + 1);
        flip_mask = mask;
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        for (int j = 0; j < len; j++) begin
            if (j > 0) tick();
            idx   = j / (s + 1);
            v     = 2'(idx);
            prior = 4'((1 << idx) - 1);
            check($sformatf("%s_run_j%0d", tag, j), observe(sel),
                  pack_exp(1'b1, 1'b0, 1'b0, v[1], v[0],
                           4'($countones(mask & prior)), mask & prior));
            if (noise && j < len - 1) set_start(sel, 1'($urandom_range(0, 1)));
            else                      set_start(sel, 1'b0);
        end
        tick();
        exp_err = 4'($countones(mask));
        check($sformatf("%s_done", tag), observe(sel),
              pack_exp(1'b0, 1'b1, exp_err == 4'd0, 1'b0, 1'b0, exp_err, mask));
        tick();
        check($sformatf("%s_idle_hold", tag), observe(sel),
              pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_err, mask));
    endtask

    initial begin
        int         sel;
        logic [3:0] m;
        int         e;

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; flip_mask = 4'b0000;
        tick();
        start1 = 1'b1;  // reset must override start
        tick();
        check("reset_dut1", observe(0), 13'd0);
        check("reset_dut3", observe(1), 13'd0);
        rst = 1'b0; start1 = 1'b0;
        tick();
        check("idle_after_reset", observe(0), 13'd0);

        // Directed runs: correct gate, c tied 0, c = a|b
        run_seq(0, 4'b0000, 1'b0, "xor_ok_s1");
        run_seq(0, 4'b0110, 1'b0, "tie0_s1");
        run_seq(0, 4'b1000, 1'b0, "or_s1");
        run_seq(1, 4'b1000, 1'b0, "or_s3");
        run_seq(1, 4'b0000, 1'b0, "xor_ok_s3");

        // Reset during vector 2 discards the partial result
        flip_mask = 4'b1111;
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        repeat (4) tick();
        check("pre_rst_vec2", observe(0),
              pack_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'b0011));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_run_rst", observe(0), 13'd0);
        tick();
        check("rst_stays_idle", observe(0), 13'd0);
        run_seq(0, 4'b0000, 1'b0, "after_rst");

`ifdef XOR_BIST_LOOP_EN
        // Held start loops and accumulates, saturating at 15
        flip_mask = 4'b0110;
        set_start(0, 1'b1);
        tick();
        for (int r = 0; r < 9; r++) begin
            repeat (8) tick();
            e = (2 * (r + 1) > 15) ? 15 : 2 * (r + 1);
            check($sformatf("loop_done_r%0d", r), observe(0),
                  pack_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(e), 4'b0110));
            tick();
            check($sformatf("loop_restart_r%0d", r), observe(0),
                  pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'(e), 4'b0110));
        end
        set_start(0, 1'b0);
        repeat (9) tick();
        check("loop_exit_idle", observe(0),
              pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 4'b0110));
`else
        // Held start: no restart, DONE held until start drops
        flip_mask = 4'b0110;
        set_start(0, 1'b1);
        tick();
        repeat (8) tick();
        check("held_done", observe(0),
              pack_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'b0110));
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("held_stay_%0d", k), observe(0),
                  pack_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'b0110));
        end
        set_start(0, 1'b0);
        tick();
        check("held_release_idle", observe(0),
              pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'b0110));
`endif
        run_seq(0, 4'b0000, 1'b0, "fresh_clear");

        // Randomized runs with start noise while busy
        for (int k = 0; k < 20; k++) begin
            sel = int'($urandom_range(0, 1));
            m   = 4'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            run_seq(sel, m, 1'b1, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xor_bist_ctrl.md
XOR_BIST_CTRL -- requirements
Module: xor_bist_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the number of cycles a/b are held before c is sampled; legal range 1..15, with 0 treated as 1.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: level request to run the test sequence.
REQ-005 Port c, input, 1 bit: output of the xor gate under test.
REQ-006 Port a, output, 1 bit: registered first operand driven to the gate.
REQ-007 Port b, output, 1 bit: registered second operand driven to the gate.
REQ-008 Port busy, output, 1 bit: high while a sequence is in progress.
REQ-009 Port done, output, 1 bit: high while in state DONE.
REQ-010 Port pass, output, 1 bit: high when done is high and err_cnt is 0.
REQ-011 Port err_cnt, output, 4 bits: mismatch count, saturating at 15.
REQ-012 Port fail_vec, output, 4 bits: bit i is set if vector i mismatched.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, DRIVE, SAMPLE and DONE.
REQ-014 The vectors {a,b} SHALL be applied in the order 0:00, 1:01, 2:10, 3:11.
REQ-015 In IDLE with start=1, the next edge SHALL load {a,b}=00, clear err_cnt and fail_vec, and enter DRIVE.
REQ-016 The FSM SHALL remain in DRIVE for SETTLE cycles, then enter SAMPLE for 1 cycle.
REQ-017 On the edge leaving SAMPLE, the block SHALL compare c against a^b; on mismatch it SHALL increment err_cnt (saturating) and set fail_vec[vector index].
REQ-018 On that same edge, the block SHALL load the next vector and return to DRIVE; after vector 3 it SHALL instead load {a,b}=00 and enter DONE.
REQ-019 Each vector SHALL occupy SETTLE+1 cycles; done SHALL rise 4*(SETTLE+1) edges after the edge on which start was sampled (SETTLE=1: 8 edges).
REQ-020 busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 Results SHALL be held stable throughout DONE.
REQ-023 DONE SHALL exit to IDLE on the first edge with start=0; err_cnt and fail_vec SHALL hold until the next run starts.
REQ-024 The c input SHALL be sampled only in SAMPLE; c is don't-care in every other state.

Reset
REQ-025 With rst=1 at an edge, the block SHALL enter IDLE and set a, b, busy, done, pass, err_cnt and fail_vec to 0.
REQ-026 rst SHALL override start and any in-progress sequence; reset mid-run SHALL abort the sequence with no partial result retained.
REQ-027 The first start after rst deasserts SHALL run a complete sequence.

Configuration
REQ-028 The macro XOR_BIST_LOOP_EN SHALL select looping behaviour.
REQ-029 With XOR_BIST_LOOP_EN defined: if start=1 on the DONE cycle, the FSM SHALL enter DRIVE with vector 00 on the next edge (done high for 1 cycle).
REQ-030 With XOR_BIST_LOOP_EN defined: err_cnt and fail_vec SHALL accumulate across looped runs and clear only on a start from IDLE or on rst.
REQ-031 Without XOR_BIST_LOOP_EN: one-shot operation per REQ-023, and no loop logic synthesised.

Verification
REQ-032 Correct XOR on c, SETTLE=1, 1-cycle start pulse -> {a,b} = 00,01,10,11 for 2 cycles each; done=1 8 edges after start; pass=1, err_cnt=0, fail_vec=0000; a=b=0 in DONE.
REQ-033 c tied 0 -> err_cnt=2, fail_vec=0110, pass=0.
REQ-034 c driven as a|b -> err_cnt=1, fail_vec=1000; with SETTLE=3, done at edge 16.
REQ-035 rst=1 during vector 2 -> all outputs 0 and IDLE on the next edge; a following start pulse with correct c -> pass=1.
REQ-036 start held high through the run (loop macro off) -> no restart, done stays 1; start low -> IDLE; new start -> counters cleared.
REQ-037 XOR_BIST_LOOP_EN defined, start held, c tied 0 -> err_cnt reads 2, 4, 6, ... at successive done pulses, saturating at 15.
